rgb2gray_controller: RTL and testbench

RGB2GRAY_CONTROLLER -- requirements
Module: rgb2gray_controller

---
 rtl/rgb2gray_controller.sv | 107 ++++++++++
 tb/tb_rgb2gray_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_controller.sv
// Control FSM for a shift-and-add RGB to grayscale converter.
// Sequences clear/load strobes into an external accumulator and counts pixels per frame.
module rgb2gray_controller #(
    parameter int FRAME_PIXELS = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             pix_valid_i,
    input  logic [23:0]      pix_rgb_i,
    output logic             pix_ready_o,
    output logic             clear_o,
    output logic             ld_o,
    output logic [9:0]       operand_o,
    output logic             gray_valid_o,
    input  logic             gray_ready_i,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] pix_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ADD_R,
        ADD_G,
        ADD_B,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [23:0]      pix_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             done_hs;

    assign accept  = (state_q == IDLE) && enable_i && pix_valid_i;
    assign done_hs = (state_q == DONE) && gray_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pix_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pix_q <= pix_rgb_i;
            end
            if (done_hs) begin
                cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Weights are pure shifts: R/4 + G/2 + B/4, peaking at 253 so the 10-bit adder never overflows
    always_comb begin
        state_d      = state_q;
        pix_ready_o  = 1'b0;
        clear_o      = 1'b0;
        ld_o         = 1'b0;
        operand_o    = '0;
        gray_valid_o = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                pix_ready_o = enable_i;
                if (accept) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clear_o = 1'b1;
                state_d = ADD_R;
            end
            ADD_R: begin
                ld_o      = 1'b1;
                operand_o = {4'b0, pix_q[23:18]};
                state_d   = ADD_G;
            end
            ADD_G: begin
                ld_o      = 1'b1;
                operand_o = {3'b0, pix_q[15:9]};
                state_d   = ADD_B;
            end
            ADD_B: begin
                ld_o      = 1'b1;
                operand_o = {4'b0, pix_q[7:2]};
                state_d   = DONE;
            end
            DONE: begin
                gray_valid_o = 1'b1;
                if (gray_ready_i) begin
                    frame_done_o = (cnt_q == LAST_IDX);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_cnt_o = cnt_q;

endmodule

// File: tb/tb_rgb2gray_controller.sv
// Directed bench for rgb2gray_controller with a behavioural accumulator standing in for the datapath.
module tb_rgb2gray_controller;

    localparam int FP    = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic [23:0] rgb;
        int          op_r;
        int          op_g;
        int          op_b;
        int          gray;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             enable_i;
    logic             pix_valid_i;
    logic [23:0]      pix_rgb_i;
    logic             pix_ready_o;
    logic             clear_o;
    logic             ld_o;
    logic [9:0]       operand_o;
    logic             gray_valid_o;
    logic             gray_ready_i;
    logic             frame_done_o;
    logic [CNT_W-1:0] pix_cnt_o;

    logic [9:0] acc;
    int         total = 0;
    int         bad = 0;
    int         exp_cnt = 0;
    int         pulses = 0;
    vec_t       vecs[5];

    rgb2gray_controller #(.FRAME_PIXELS(FP), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .pix_valid_i  (pix_valid_i),
        .pix_rgb_i    (pix_rgb_i),
        .pix_ready_o  (pix_ready_o),
        .clear_o      (clear_o),
        .ld_o         (ld_o),
        .operand_o    (operand_o),
        .gray_valid_o (gray_valid_o),
        .gray_ready_i (gray_ready_i),
        .frame_done_o (frame_done_o),
        .pix_cnt_o    (pix_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in for the datapath accumulator driven by the strobes
    always @(posedge clk_i) begin
        if (clear_o) acc <= '0;
        else if (ld_o) acc <= acc + operand_o;
        if (frame_done_o) pulses <= pulses + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One full pixel: accept, strobe sequence, optional backpressure, DONE exit
    task automatic applyStimulus(input vec_t v, input int hold, input bit drop_en);
        @(negedge clk_i);
        enable_i    = 1'b1;
        pix_valid_i = 1'b1;
        pix_rgb_i   = v.rgb;
        #1;
        checkOutput("ready_idle", pix_ready_o, 1);
        @(negedge clk_i);
        pix_valid_i = 1'b0;
        pix_rgb_i   = 24'hABCDEF;
        #1;
        checkOutput("clear_t1", clear_o, 1);
        checkOutput("ld_t1", ld_o, 0);
        checkOutput("op_t1", operand_o, 0);
        @(negedge clk_i);
        pix_valid_i = 1'b1;
        #1;
        checkOutput("ld_r", ld_o, 1);
        checkOutput("op_r", operand_o, v.op_r);
        checkOutput("clear_r", clear_o, 0);
        @(negedge clk_i);
        if (drop_en) enable_i = 1'b0;
        #1;
        checkOutput("ld_g", ld_o, 1);
        checkOutput("op_g", operand_o, v.op_g);
        @(negedge clk_i);
        pix_valid_i = 1'b0;
        #1;
        checkOutput("ld_b", ld_o, 1);
        checkOutput("op_b", operand_o, v.op_b);
        @(negedge clk_i);
        #1;
        checkOutput("gray_valid_t5", gray_valid_o, 1);
        checkOutput("gray_value", acc, v.gray);
        checkOutput("ld_done", ld_o, 0);
        checkOutput("clear_done", clear_o, 0);
        pix_valid_i = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("bp_valid", gray_valid_o, 1);
            checkOutput("bp_ready", pix_ready_o, 0);
            checkOutput("bp_ld", ld_o, 0);
            checkOutput("bp_clear", clear_o, 0);
            checkOutput("bp_cnt", pix_cnt_o, exp_cnt);
            checkOutput("bp_gray", acc, v.gray);
        end
        pix_valid_i  = 1'b0;
        gray_ready_i = 1'b1;
        #1;
        checkOutput("frame_done", frame_done_o, (exp_cnt == FP - 1) ? 1 : 0);
        checkOutput("cnt_before_exit", pix_cnt_o, exp_cnt);
        @(negedge clk_i);
        gray_ready_i = 1'b0;
        exp_cnt      = (exp_cnt + 1) % FP;
        #1;
        checkOutput("idle_valid", gray_valid_o, 0);
        checkOutput("cnt_after_exit", pix_cnt_o, exp_cnt);
        checkOutput("frame_done_after", frame_done_o, 0);
        checkOutput("ready_after", pix_ready_o, enable_i);
        enable_i = 1'b1;
    endtask

    initial begin
        vecs[0] = '{24'hFFFFFF, 63, 127, 63, 253};
        vecs[1] = '{24'h4080C0, 16, 64, 48, 128};
        vecs[2] = '{24'h000000, 0, 0, 0, 0};
        vecs[3] = '{24'h123456, 4, 26, 21, 51};
        vecs[4] = '{24'h0703FC, 1, 1, 63, 65};

        rst_i        = 1'b0;
        enable_i     = 1'b1;
        pix_valid_i  = 1'b0;
        pix_rgb_i    = '0;
        gray_ready_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        #1;
        checkOutput("rst_ready_en1", pix_ready_o, 1);
        checkOutput("rst_clear", clear_o, 0);
        checkOutput("rst_ld", ld_o, 0);
        checkOutput("rst_op", operand_o, 0);
        checkOutput("rst_valid", gray_valid_o, 0);
        checkOutput("rst_cnt", pix_cnt_o, 0);
        checkOutput("rst_fdone", frame_done_o, 0);
        enable_i = 1'b0;
        #1;
        checkOutput("rst_ready_en0", pix_ready_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Enable low blocks acceptance
        enable_i    = 1'b0;
        pix_valid_i = 1'b1;
        pix_rgb_i   = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("en0_ready", pix_ready_o, 0);
            checkOutput("en0_clear", clear_o, 0);
            checkOutput("en0_valid", gray_valid_o, 0);
        end
        pix_valid_i = 1'b0;
        enable_i    = 1'b1;

        // Table of pixels; the 4th crosses the frame boundary
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 0, 1'b0);
            if (i == 3) checkOutput("wrap_cnt_zero", pix_cnt_o, 0);
        end
        checkOutput("frame_pulses", pulses, 1);

        // Backpressure for 10 cycles
        applyStimulus(vecs[1], 10, 1'b0);

        // Enable dropped during ADD_G still completes
        applyStimulus(vecs[3], 0, 1'b1);

        // Reset asserted in ADD_G
        @(negedge clk_i);
        pix_valid_i = 1'b1;
        pix_rgb_i   = 24'h102030;
        @(negedge clk_i);
        pix_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checkOutput("pre_rst_ld_g", ld_o, 1);
        checkOutput("pre_rst_op_g", operand_o, 16);
        rst_i = 1'b0;
        #1;
        checkOutput("mid_rst_ld", ld_o, 0);
        checkOutput("mid_rst_op", operand_o, 0);
        checkOutput("mid_rst_clear", clear_o, 0);
        checkOutput("mid_rst_valid", gray_valid_o, 0);
        checkOutput("mid_rst_cnt", pix_cnt_o, 0);
        checkOutput("mid_rst_ready", pix_ready_o, enable_i);
        @(negedge clk_i);
        rst_i   = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            #1;
            checkOutput("post_rst_no_clear", clear_o, 0);
            checkOutput("post_rst_no_ld", ld_o, 0);
        end
        applyStimulus('{24'h102030, 4, 16, 12, 32}, 0, 1'b0);
        checkOutput("final_pulses", pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
